// File: rtl/bist_misr_ora.sv
// Output response analyzer: compacts NUM_PATTERNS qualified products into a Galois MISR and checks the
// final signature. Define ORA_GOLDEN_PORT_EN to take the expected signature from golden_in, latched on start.
module bist_misr_ora #(
  parameter int          NUM_PATTERNS = 16,
  parameter logic [7:0]  POLY         = 8'h1D,
  parameter logic [7:0]  GOLDEN       = 8'h26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
`ifdef ORA_GOLDEN_PORT_EN
  input  logic [7:0] golden_in,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [7:0] signature,
  output logic [7:0] count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_PATTERNS - 1);

  state_t     state_q, state_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] golden_cmp;
  logic [7:0] misr_next;

`ifdef ORA_GOLDEN_PORT_EN
  logic [7:0] golden_q, golden_d;
  assign golden_cmp = golden_q;
`else
  assign golden_cmp = GOLDEN;
`endif

  always_comb begin
    misr_next    = '0;
    misr_next[0] = sig_q[7] ^ data_in[0];
    for (int i = 1; i < 8; i++) begin
      misr_next[i] = sig_q[i-1] ^ data_in[i] ^ (POLY[i] & sig_q[7]);
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
`ifdef ORA_GOLDEN_PORT_EN
    golden_d = golden_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = COMPACT;
          sig_d    = '0;
          cnt_d    = '0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
`ifdef ORA_GOLDEN_PORT_EN
          golden_d = golden_in;
`endif
        end
      end
      COMPACT: begin
        if (data_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        state_d = DONE;
        pass_d  = (sig_q == golden_cmp);
        fail_d  = (sig_q != golden_cmp);
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they change on the same edge as the state.
    busy_d = (state_d == COMPACT) || (state_d == COMPARE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ORA_GOLDEN_PORT_EN
      golden_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ORA_GOLDEN_PORT_EN
      golden_q <= golden_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_bist_misr_ora.sv
// Bench for bist_misr_ora: random and directed streams checked against a GF(2^8) signature model.
module tb_bist_misr_ora;
  localparam int         N      = 16;
  localparam logic [7:0] POLY   = 8'h1D;
  localparam logic [7:0] GOLDEN = 8'h26;

  logic       clk = 1'b0;
  logic       reset, start, data_valid;
  logic [7:0] data_in, golden_in;
  logic       busy, done, pass, fail;
  logic [7:0] signature, count;
  logic       z_busy, z_done, z_pass, z_fail;
  logic [7:0] z_signature, z_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] stim[N];

  bist_misr_ora #(.NUM_PATTERNS(N), .POLY(POLY), .GOLDEN(GOLDEN)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
`ifdef ORA_GOLDEN_PORT_EN
    .golden_in(golden_in),
`endif
    .busy(busy), .done(done), .pass(pass), .fail(fail), .signature(signature), .count(count)
  );

  // Second instance expects an all-zero signature.
  bist_misr_ora #(.NUM_PATTERNS(N), .POLY(POLY), .GOLDEN(8'h00)) dut_z (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
`ifdef ORA_GOLDEN_PORT_EN
    .golden_in(8'h00),
`endif
    .busy(z_busy), .done(z_done), .pass(z_pass), .fail(z_fail), .signature(z_signature), .count(z_count)
  );

  always #5 clk = ~clk;

  // Signature as polynomial arithmetic: s <- s*x mod (x^8 + POLY) + d.
  function automatic logic [7:0] gf_mulx(input logic [7:0] a);
    logic [7:0] sh;
    sh = a << 1;
    return a[7] ? (sh ^ POLY) : sh;
  endfunction

  function automatic logic [7:0] ref_sig();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < N; i++) s = gf_mulx(s) ^ stim[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    tick();
    start      = 1'b0;
  endtask

  // gap < 0 selects a random gap of 0..3 idle cycles before each sample.
  task automatic feed(input int gap);
    int g;
    for (int i = 0; i < N; i++) begin
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        tick();
      end
      data_valid = 1'b1;
      data_in    = stim[i];
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00; golden_in = GOLDEN;
    #12;
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, pass, fail, signature, count} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b fail=%b sig=%h cnt=%h, want all 0",
               busy, done, pass, fail, signature, count);
    end
  endtask

  task automatic test_zero_stream();
    for (int i = 0; i < N; i++) stim[i] = 8'h00;
    do_start();
    feed(0);
    tick();
    checks++;
    if (z_signature !== 8'h00 || z_count !== 8'd16 || z_done !== 1'b1 || z_pass !== 1'b1 || z_fail !== 1'b0) begin
      failures++;
      $display("FAIL zero_stream_g0: got sig=%h cnt=%0d done=%b pass=%b fail=%b, want 00 16 1 1 0",
               z_signature, z_count, z_done, z_pass, z_fail);
    end
    checks++;
    if (signature !== 8'h00 || done !== 1'b1 || pass !== 1'b0 || fail !== 1'b1) begin
      failures++;
      $display("FAIL zero_stream_g26: got sig=%h done=%b pass=%b fail=%b, want 00 1 0 1",
               signature, done, pass, fail);
    end
  endtask

  task automatic test_defaults();
    for (int i = 0; i < N; i++) stim[i] = 8'h00;
    stim[0] = 8'h01;
    do_start();
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0 || count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: got pass=%b fail=%b cnt=%0d busy=%b done=%b, want 0 0 0 1 0",
               pass, fail, count, busy, done);
    end
    feed(0);
    tick();
    checks++;
    if (signature !== 8'h26 || pass !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL default_pass: got sig=%h pass=%b fail=%b, want 26 1 0", signature, pass, fail);
    end
    stim[0] = 8'h02;
    do_start();
    feed(0);
    tick();
    checks++;
    if (signature !== ref_sig() || pass !== 1'b0 || fail !== 1'b1) begin
      failures++;
      $display("FAIL default_fail: got sig=%h pass=%b fail=%b, want %h 0 1", signature, pass, fail, ref_sig());
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N; i++) stim[i] = 8'h00;
    stim[0] = 8'h01;
    do_start();
    feed(3);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || count !== 8'd16) begin
      failures++;
      $display("FAIL gap_compare_cycle: got done=%b busy=%b cnt=%0d, want 0 1 16", done, busy, count);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || signature !== 8'h26 || pass !== 1'b1) begin
      failures++;
      $display("FAIL gap_done: got done=%b busy=%b sig=%h pass=%b, want 1 0 26 1", done, busy, signature, pass);
    end
    data_valid = 1'b1; data_in = 8'hFF;
    tick(); tick();
    data_valid = 1'b0;
    checks++;
    if (signature !== 8'h26 || count !== 8'd16 || pass !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold: got sig=%h cnt=%0d pass=%b done=%b, want 26 16 1 1", signature, count, pass, done);
    end
  endtask

  task automatic test_ignored();
    reset = 1'b1; #2; reset = 1'b0;
    data_valid = 1'b1; data_in = 8'hFF;
    tick(); tick(); tick();
    checks++;
    if (count !== 8'd0 || signature !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid_ignored: got cnt=%0d sig=%h busy=%b, want 0 00 0", count, signature, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count !== 8'd0 || signature !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_cycle_valid_ignored: got cnt=%0d sig=%h busy=%b, want 0 00 1", count, signature, busy);
    end
    for (int i = 0; i < N; i++) stim[i] = 8'h00;
    stim[0] = 8'h01;
    for (int i = 0; i < N; i++) begin
      data_valid = 1'b0; start = (i == 5); data_in = 8'hFF;
      tick();
      start = 1'b0;
      data_valid = 1'b1; data_in = stim[i];
      tick();
      if (i == 7) begin
        checks++;
        if (count !== 8'd8) begin
          failures++;
          $display("FAIL midrun_count: got %0d want 8", count);
        end
      end
    end
    data_valid = 1'b0;
    tick();
    checks++;
    if (signature !== 8'h26 || pass !== 1'b1 || count !== 8'd16) begin
      failures++;
      $display("FAIL start_in_compact_ignored: got sig=%h pass=%b cnt=%0d, want 26 1 16", signature, pass, count);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
    do_start();
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1; data_in = stim[i];
      tick();
    end
    data_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail, signature, count} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b pass=%b fail=%b sig=%h cnt=%h, want all 0",
               busy, done, pass, fail, signature, count);
    end
    tick();
    reset = 1'b0;
    do_start();
    feed(1);
    tick();
    checks++;
    if (signature !== ref_sig() || count !== 8'd16 || pass !== (ref_sig() == GOLDEN) || done !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_run: got sig=%h cnt=%0d pass=%b done=%b, want %h 16 %b 1",
               signature, count, pass, done, ref_sig(), ref_sig() == GOLDEN);
    end
  endtask

  task automatic test_random_runs();
    logic [7:0] exp;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
      if (r == 2) stim[N-1] = stim[N-1] ^ ref_sig() ^ GOLDEN;  // force one matching run
      exp = ref_sig();
      do_start();
      feed(-1);
      tick();
      checks++;
      if (signature !== exp || count !== 8'd16 || pass !== (exp == GOLDEN) || fail !== (exp != GOLDEN)
          || done !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_run_%0d: got sig=%h cnt=%0d pass=%b fail=%b done=%b busy=%b, want %h 16 %b %b 1 0",
                 r, signature, count, pass, fail, done, busy, exp, exp == GOLDEN, exp != GOLDEN);
      end
      checks++;
      if (z_pass !== (exp == 8'h00) || z_fail !== (exp != 8'h00)) begin
        failures++;
        $display("FAIL random_run_z_%0d: got pass=%b fail=%b, want %b %b", r, z_pass, z_fail, exp == 8'h00, exp != 8'h00);
      end
    end
  endtask

`ifdef ORA_GOLDEN_PORT_EN
  task automatic test_golden_port();
    for (int i = 0; i < N; i++) stim[i] = 8'h00;
    stim[0] = 8'h01;
    golden_in = 8'h26;
    do_start();
    for (int i = 0; i < N; i++) begin
      if (i == 4) golden_in = 8'h00;
      data_valid = 1'b1; data_in = stim[i];
      tick();
    end
    data_valid = 1'b0;
    tick();
    checks++;
    if (signature !== 8'h26 || pass !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL golden_port_latch: got sig=%h pass=%b fail=%b, want 26 1 0", signature, pass, fail);
    end
    golden_in = GOLDEN;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_stream();
    test_defaults();
    test_gaps();
    test_ignored();
    test_reset_midrun();
    test_random_runs();
`ifdef ORA_GOLDEN_PORT_EN
    test_golden_port();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
